// File: rtl/p_s_converter.sv
// p_s_converter: MSB-first parallel-to-serial converter, valid/ready load.
// Optional even-parity trailer bit when PS_PARITY_EN is defined.
module p_s_converter #(
  parameter int C_BITS_IN = 255
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 LOAD_VALID,
  output logic                 LOAD_READY,
  input  logic [C_BITS_IN-1:0] P_IN,
  output logic                 Q,
  output logic                 Q_VALID,
  output logic                 FRAME_START
);

`ifdef PS_PARITY_EN
  localparam int CW = $clog2(C_BITS_IN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(C_BITS_IN);
`else
  localparam int CW = $clog2(C_BITS_IN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(C_BITS_IN - 1);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q;
  logic [C_BITS_IN-1:0] sr_q;
  logic [C_BITS_IN-1:0] sr_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 q_q;
  logic                 qv_q;
  logic                 fs_q;
  logic                 bit_d;
  logic                 last_w;
  logic                 load_w;
`ifdef PS_PARITY_EN
  logic                 par_q;
`endif

  assign last_w     = (cnt_q == '0);
  assign LOAD_READY = ~RST & ((state_q == IDLE) | last_w);
  assign load_w     = LOAD_VALID & LOAD_READY;

  assign Q           = q_q;
  assign Q_VALID     = qv_q;
  assign FRAME_START = fs_q;

  // Next shift-register image, counter value and outgoing bit.
  always_comb begin
    sr_d  = {sr_q[C_BITS_IN-2:0], 1'b0};
    cnt_d = cnt_q - CW'(1);
`ifdef PS_PARITY_EN
    bit_d = (cnt_q == CW'(1)) ? par_q : sr_q[C_BITS_IN-1];
`else
    bit_d = sr_q[C_BITS_IN-1];
`endif
  end

  // Load/shift FSM with registered serial outputs; reset wins.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      qv_q    <= 1'b0;
      fs_q    <= 1'b0;
`ifdef PS_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (load_w) begin
      state_q <= SHIFT;
      sr_q    <= {P_IN[C_BITS_IN-2:0], 1'b0};
      cnt_q   <= CNT_LOAD;
      q_q     <= P_IN[C_BITS_IN-1];
      qv_q    <= 1'b1;
      fs_q    <= 1'b1;
`ifdef PS_PARITY_EN
      par_q   <= ^P_IN;
`endif
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (!last_w) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            q_q   <= bit_d;
            qv_q  <= 1'b1;
            fs_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
            fs_q    <= 1'b0;
          end
        end
        default: begin
          q_q  <= 1'b0;
          qv_q <= 1'b0;
          fs_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
